// File: rtl/uart_rx_if.sv
// Load-path pop interface of the UART receiver: show-ahead FIFO head plus pop request.
interface uart_rx_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             rEn;
  logic [7:0]       rData;
  logic             rxValid;
  logic [CNT_W-1:0] fifoCount;
  logic             fifoFull;

  modport master (input rEn, output rData, rxValid, fifoCount, fifoFull);
  modport slave  (output rEn, input rData, rxValid, fifoCount, fifoFull);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling FSM,
// show-ahead receive FIFO and sticky overrun / framing-error flags.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on the synchronised input
// START  | timing to mid start bit to reject glitches
// DATA   | sampling 8 data bits LSB first, one per bit period
// STOP   | sampling the stop bit, then push / drop the byte
// WAITHI | stop bit was low; wait for the line to return high
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sIn,
  input  logic errClr,
  output logic overrun,
  output logic frameErr,
  output logic busy,
  uart_rx_if.master rd
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FC_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [FC_W-1:0]  FC_FULL  = FC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             rx_meta, rx_s;
  logic             push, set_ovr, set_fe;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [FC_W-1:0]  count;
  logic             full, valid, pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= sIn;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    push        = 1'b0;
    set_ovr     = 1'b0;
    set_fe      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = DATA;
            bit_idx_nxt = '0;
          end
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt            = '0;
          shift_nxt[bit_idx] = rx_s;
          bit_idx_nxt        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (!rx_s) begin
            set_fe    = 1'b1;
            state_nxt = WAITHI;
          end else if (!full || pop) begin
            // a same-cycle pop frees the slot this byte lands in
            push = 1'b1;
          end else begin
            set_ovr = 1'b1;
          end
        end
      end
      WAITHI: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign valid = (count != '0);
  assign full  = (count == FC_FULL);
  assign pop   = rd.rEn && valid;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun  <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      if (set_ovr)     overrun <= 1'b1;
      else if (errClr) overrun <= 1'b0;
      if (set_fe)      frameErr <= 1'b1;
      else if (errClr) frameErr <= 1'b0;
    end
  end

  // head is gated so an empty FIFO reads as zero regardless of stale storage
  assign rd.rData     = valid ? mem[rd_ptr] : 8'h00;
  assign rd.rxValid   = valid;
  assign rd.fifoCount = count;
  assign rd.fifoFull  = full;
  assign busy         = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit by bit, the expected byte
// stream and flags come from a queue model, and a monitor pops and compares.
module tb_uart_rx;
  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  // clock edge (counted from the start-bit drive) at which the stop bit is sampled
  localparam int STOP_EDGE = 3 + CPB / 2 + 9 * CPB;

  logic clk = 1'b0;
  logic rst, sIn, errClr;
  logic overrun, frameErr, busy;

  uart_rx_if #(.FIFO_DEPTH(DEPTH)) rd ();

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sIn(sIn), .errClr(errClr),
    .overrun(overrun), .frameErr(frameErr), .busy(busy), .rd(rd)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  bit         pop_en = 1'b0;
  int         force_req = 0;
  int         force_ack = 0;
  bit         exp_ovr = 1'b0;
  bit         exp_fe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // monitor: decides rEn for the next edge and checks every byte it pops
  initial begin
    bit do_pop;
    rd.rEn = 1'b0;
    forever begin
      @(negedge clk);
      do_pop = 1'b0;
      if (force_req != force_ack) begin
        force_ack++;
        do_pop = 1'b1;
      end else if (pop_en && rd.rxValid) begin
        do_pop = 1'b1;
      end
      if (do_pop && rd.rxValid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL pop_unexpected: got %0h, expected no byte", rd.rData);
        end else begin
          check("pop_data", {24'h0, rd.rData}, {24'h0, exp_q.pop_front()});
        end
      end
      rd.rEn = do_pop;
    end
  end

  // drives one 8N1 frame; optionally requests a pop landing on the stop-sample edge
  task automatic send_frame(input logic [7:0] b, input bit stop_val, input int pop_cycle);
    logic [9:0] fr;
    int c;
    fr = {stop_val, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      sIn = fr[i];
      for (int j = 0; j < CPB; j++) begin
        c = i * CPB + j;
        if (c == pop_cycle) force_req++;
        tick(1);
        if (c == STOP_EDGE - 1) begin
          if (!stop_val)                exp_fe = 1'b1;
          else if (exp_q.size() < DEPTH) exp_q.push_back(b);
          else                           exp_ovr = 1'b1;
        end
      end
    end
  endtask

  task automatic drain();
    int t;
    pop_en = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || rd.rxValid) && t < 100) begin
      tick(1);
      t++;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_rxvalid", rd.rxValid, 0);
  endtask

  task automatic clear_flags();
    errClr = 1'b1;
    tick(1);
    errClr = 1'b0;
    exp_ovr = 1'b0;
    exp_fe  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rxvalid"}, rd.rxValid, 0);
    check({tag, "_count"}, rd.fifoCount, 0);
    check({tag, "_full"}, rd.fifoFull, 0);
    check({tag, "_rdata"}, rd.rData, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_frameerr"}, frameErr, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int cnt0;
    logic [7:0] b;
    bit stop;
    rst = 1'b0;
    sIn = 1'b1;
    errClr = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b1;
    tick(100);
    check_reset_outputs("idle");

    // single byte, held then popped
    send_frame(8'hA5, 1'b1, -1);
    tick(CPB);
    check("a5_rxvalid", rd.rxValid, 1);
    check("a5_rdata", rd.rData, 8'hA5);
    check("a5_count", rd.fifoCount, 1);
    check("a5_frameerr", frameErr, 0);
    drain();
    check("a5_count_after", rd.fifoCount, 0);

    // start-bit glitch
    sIn = 1'b0;
    tick(5);
    check("glitch_busy", busy, 1);
    sIn = 1'b1;
    tick(8);
    check("glitch_idle", busy, 0);
    check("glitch_count", rd.fifoCount, 0);

    // overrun: nine bytes, no pops
    pop_en = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b1, -1);
      tick(2);
    end
    check("fill_full", rd.fifoFull, 1);
    check("fill_count", rd.fifoCount, DEPTH);
    check("fill_overrun", overrun, exp_ovr);
    drain();
    clear_flags();
    check("ovr_cleared", overrun, 0);

    // framing error and break
    cnt0 = int'(rd.fifoCount);
    send_frame(8'h3C, 1'b0, -1);
    check("fe_set", frameErr, exp_fe);
    check("fe_count", rd.fifoCount, cnt0);
    tick(100);
    check("break_busy", busy, 1);
    check("break_count", rd.fifoCount, cnt0);
    check("break_frameerr", frameErr, 1);
    sIn = 1'b1;
    tick(5);
    check("break_release", busy, 0);
    clear_flags();
    check("fe_cleared", frameErr, 0);
    pop_en = 1'b0;
    send_frame(8'h55, 1'b1, -1);
    tick(4);
    check("after_break_rdata", rd.rData, 8'h55);
    drain();

    // full FIFO with a pop on the stop-sample edge of the ninth byte
    pop_en = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      send_frame(8'(i), 1'b1, -1);
      tick(2);
    end
    send_frame(8'h09, 1'b1, STOP_EDGE - 1);
    tick(2);
    check("coinc_overrun", overrun, 0);
    check("coinc_count", rd.fifoCount, DEPTH);
    check("coinc_full", rd.fifoFull, 1);
    drain();

    // randomized frames with random popping and occasional bad stop bits
    for (int n = 0; n < 24; n++) begin
      pop_en = ($urandom_range(0, 3) != 0);
      b = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      send_frame(b, stop, -1);
      check("rand_count", rd.fifoCount, exp_q.size());
      check("rand_overrun", overrun, exp_ovr);
      check("rand_frameerr", frameErr, exp_fe);
      sIn = 1'b1;
      tick($urandom_range(2, 20));
      if (exp_ovr || exp_fe) clear_flags();
    end
    drain();

    // reset in the middle of a frame
    pop_en = 1'b0;
    send_frame(8'h77, 1'b1, -1);
    tick(2);
    sIn = 1'b0;
    tick(40);
    check("midrst_busy_before", busy, 1);
    rst = 1'b0;
    #2;
    check_reset_outputs("midrst");
    exp_q.delete();
    sIn = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(200);
    check_reset_outputs("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
